mips_step_ctrl: RTL and testbench

//   Run/single-step front end for the mips core, placed directly upstream of its change/step inputs.
//   - Synchronizes and debounces the raw change (mode toggle) and step (single-step request) buttons.
//   - Produces a clean per-cycle advance enable, cpu_en, for the core.
//   - Keeps a count of single steps issued.

---
 rtl/mips_step_ctrl_if.sv | 30 +++
 rtl/mips_step_ctrl.sv | 102 ++++++++++
 tb/tb_mips_step_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_step_ctrl_if.sv
// Button/enable bundle between the board controls and the mips run/step front end.
// The master drives the raw buttons; the slave (mips_step_ctrl) drives the core-facing outputs.
interface mips_step_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             change_in;
  logic             step_in;
  logic             cpu_en;
  logic             mode_run;
  logic             step_pulse;
  logic [CNT_W-1:0] step_count;

  modport master (
    output change_in,
    output step_in,
    input  cpu_en,
    input  mode_run,
    input  step_pulse,
    input  step_count
  );

  modport slave (
    input  change_in,
    input  step_in,
    output cpu_en,
    output mode_run,
    output step_pulse,
    output step_count
  );
endinterface

// File: rtl/mips_step_ctrl.sv
// Run/single-step front end for the mips core: syncs and debounces the change/step buttons,
// sequences RUN/STEP_IDLE/STEP_FIRE and counts issued single steps.
module mips_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          START_RUN       = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input logic             clk,
  input logic             rst,
  mips_step_ctrl_if.slave bus
);

  localparam int unsigned         CntBits  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntBits-1:0]  DebLimit = CntBits'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {StRun, StStepIdle, StStepFire} state_e;

  localparam state_e ResetState = START_RUN ? StRun : StStepIdle;

  // Bit 0 carries the change button, bit 1 the step button.
  logic [1:0]         raw;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_prev_q;
  logic [1:0]         rise_q;
  logic [CntBits-1:0] cnt_q   [2];
  logic [CntBits-1:0] cnt_inc [2];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;

  assign raw = {bus.step_in, bus.change_in};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      rise_q        <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      rise_q        <= stable_q & ~stable_prev_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_inc[i] == DebLimit) begin
            stable_q[i] <= sync2_q[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_inc[i];
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // A change request always wins; step requests outside STEP_IDLE are dropped, never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (rise_q[0]) state_d = StStepIdle;
      end
      StStepIdle: begin
        if (rise_q[0])      state_d = StRun;
        else if (rise_q[1]) state_d = StStepFire;
      end
      StStepFire: begin
        state_d = rise_q[0] ? StRun : StStepIdle;
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ResetState;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StStepFire) count_q <= count_q + 1'b1;
    end
  end

  assign bus.cpu_en     = (state_q != StStepIdle);
  assign bus.mode_run   = (state_q == StRun);
  assign bus.step_pulse = (state_q == StStepFire);
  assign bus.step_count = count_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Bench for mips_step_ctrl (DEBOUNCE_CYCLES=2, START_RUN=1): directed scenarios plus random
// button activity, each cycle compared against a history-based behavioural model.
module tb_mips_step_ctrl;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mips_step_ctrl_if #(.CNT_W(16)) bus ();

  mips_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .START_RUN      (1'b1),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: raw samples are delayed two edges, then a level is accepted after D consecutive
  // disagreeing samples; acceptance of a high level becomes a request one edge later.
  bit        hist_c[$];
  bit        hist_s[$];
  bit [1:0]  m_stable, m_prev, m_req;
  int        m_run[2];
  bit        m_step_mode, m_firing;
  logic [15:0] m_count;

  function automatic void model_edge(input bit r, input bit c, input bit s);
    bit [1:0] seen;
    bit [1:0] req_now;
    if (r) begin
      hist_c = '{1'b0, 1'b0};
      hist_s = '{1'b0, 1'b0};
      m_stable = '0; m_prev = '0; m_req = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_step_mode = 1'b0; m_firing = 1'b0; m_count = '0;
    end else begin
      seen = {hist_s[0], hist_c[0]};
      hist_c.push_back(c); void'(hist_c.pop_front());
      hist_s.push_back(s); void'(hist_s.pop_front());
      req_now = m_req;
      m_req   = m_stable & ~m_prev;
      m_prev  = m_stable;
      for (int i = 0; i < 2; i++) begin
        if (seen[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_stable[i] = seen[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_firing) m_count++;
      if (!m_step_mode) begin
        if (req_now[0]) m_step_mode = 1'b1;
      end else if (m_firing) begin
        m_firing = 1'b0;
        if (req_now[0]) m_step_mode = 1'b0;
      end else if (req_now[0]) begin
        m_step_mode = 1'b0;
      end else if (req_now[1]) begin
        m_firing = 1'b1;
      end
    end
  endfunction

  function automatic logic [18:0] model_out();
    return {(!m_step_mode || m_firing), !m_step_mode, m_firing, m_count};
  endfunction

  function automatic logic [18:0] dut_out();
    return {bus.cpu_en, bus.mode_run, bus.step_pulse, bus.step_count};
  endfunction

  // Drive for one edge, advance the model on that edge, return at the following negedge.
  task automatic cycle(input bit r, input bit c, input bit s);
    rst = r;
    bus.change_in = c;
    bus.step_in   = s;
    @(posedge clk);
    model_edge(r, c, s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (dut_out() !== 19'h60000) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", dut_out(), 19'h60000);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_enter_step();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (bus.mode_run !== (i < 5) || bus.cpu_en !== (i < 5)) begin
        n_fail++;
        $display("FAIL enter_step edge k+%0d: mode_run=%b cpu_en=%b expected %b", i,
                 bus.mode_run, bus.cpu_en, (i < 5));
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_out() !== model_out() || bus.mode_run !== 1'b0) begin
        n_fail++;
        $display("FAIL enter_release[%0d]: got %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_single_step();
    logic [15:0] c0 = m_count;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (bus.step_pulse !== (i == 5) || bus.cpu_en !== (i == 5)) begin
        n_fail++;
        $display("FAIL single_step edge k+%0d: step_pulse=%b cpu_en=%b expected %b", i,
                 bus.step_pulse, bus.cpu_en, (i == 5));
      end
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.step_count !== c0 + 16'd1 || dut_out() !== model_out()) begin
      n_fail++;
      $display("FAIL single_step_count: got %0d expected %0d", bus.step_count, c0 + 16'd1);
    end
  endtask

  task automatic test_glitch();
    logic [15:0] c0 = m_count;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (bus.cpu_en !== 1'b0 || bus.step_count !== c0) begin
        n_fail++;
        $display("FAIL glitch[%0d]: cpu_en=%b count=%0d expected 0/%0d", i, bus.cpu_en,
                 bus.step_count, c0);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL press3[%0d]: got %h expected %h", i, dut_out(), model_out());
      end
    end
    n_checks++;
    if (bus.step_count !== c0 + 16'd1) begin
      n_fail++;
      $display("FAIL press3_count: got %0d expected %0d", bus.step_count, c0 + 16'd1);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] c0 = m_count;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (bus.mode_run !== (i >= 5) || bus.step_pulse !== 1'b0 || bus.step_count !== c0) begin
        n_fail++;
        $display("FAIL simultaneous k+%0d: mode_run=%b step_pulse=%b count=%0d", i,
                 bus.mode_run, bus.step_pulse, bus.step_count);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL simul_release[%0d]: got %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  task automatic test_reset_mid_step();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.step_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_step_fire: step_pulse=%b expected 1", bus.step_pulse);
    end
    cycle(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (dut_out() !== 19'h60000) begin
      n_fail++;
      $display("FAIL mid_step_reset: got %h expected %h", dut_out(), 19'h60000);
    end
    // change held through reset must be re-accepted from scratch
    for (int i = 1; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (bus.mode_run !== (i < 6) || bus.step_pulse !== 1'b0 || dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL post_reset r+%0d: got %h expected mode_run=%b model %h", i, dut_out(),
                 (i < 6), model_out());
      end
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit c = 1'b0;
    bit s = 1'b0;
    int hold_c = 0;
    int hold_s = 0;
    bit r;
    for (int i = 0; i < 1500; i++) begin
      if (hold_c == 0) begin c = $urandom_range(1, 0); hold_c = $urandom_range(8, 1); end
      if (hold_s == 0) begin s = $urandom_range(1, 0); hold_s = $urandom_range(8, 1); end
      hold_c--; hold_s--;
      r = ($urandom_range(199, 0) == 0);
      cycle(r, c, s);
      n_checks++;
      if (dut_out() !== model_out()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, dut_out(), model_out());
      end
    end
  endtask

  initial begin
    bus.change_in = 1'b0;
    bus.step_in   = 1'b0;
    @(negedge clk);
    test_reset();
    test_enter_step();
    test_single_step();
    test_glitch();
    test_simultaneous();
    test_reset_mid_step();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
